// File: rtl/rssb_ctrl.sv
// rssb_ctrl: sequencer for the reverse-subtract-and-skip-if-borrow core.
// Fetches an operand address, reads the operand, writes back mem[x] - acc
// and drives the PC/ACC register write strobes.
// Optional feature macro: RSSB_HALT_EN enables the HALT_WORD stop instruction.
module rssb_ctrl #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] HALT_WORD = 8'hFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             halted,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] acc,
    output logic             pc_we,
    output logic [WIDTH-1:0] pc_next,
    output logic             acc_we,
    output logic [WIDTH-1:0] acc_next,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        READ,
        WRITE,
        UPDATE
`ifdef RSSB_HALT_EN
        , HALT
`endif
    } state_t;

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic             pc_we_q, pc_we_d;
    logic [WIDTH-1:0] pc_next_q, pc_next_d;
    logic             acc_we_q, acc_we_d;
    logic [WIDTH-1:0] acc_next_q, acc_next_d;
    logic [WIDTH:0]   diff_q, diff_d;   // MSB is the borrow
`ifdef RSSB_HALT_EN
    logic             halted_q, halted_d;
`endif

    // Next state and next registered outputs, computed one cycle ahead
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        pc_we_d     = 1'b0;
        pc_next_d   = pc_next_q;
        acc_we_d    = 1'b0;
        acc_next_d  = acc_next_q;
        diff_d      = diff_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = FETCH;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = pc;
                end
            end
            FETCH: begin
                if (mem_ready) begin
`ifdef RSSB_HALT_EN
                    if (mem_rdata == HALT_WORD) begin
                        state_d   = HALT;
                        mem_req_d = 1'b0;
                    end else
`endif
                    begin
                        // the operand address x lives in mem_addr until WRITE completes
                        state_d    = READ;
                        mem_addr_d = mem_rdata;
                    end
                end
            end
            READ: begin
                if (mem_ready) begin
                    diff_d      = {1'b0, mem_rdata} - {1'b0, acc};
                    state_d     = WRITE;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = diff_d[WIDTH-1:0];
                end
            end
            WRITE: begin
                if (mem_ready) begin
                    state_d    = UPDATE;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    acc_we_d   = 1'b1;
                    acc_next_d = diff_q[WIDTH-1:0];
                    pc_we_d    = 1'b1;
                    pc_next_d  = pc + WIDTH'(1) + WIDTH'(diff_q[WIDTH]);
                end
            end
            UPDATE: begin
                // address is registered on the same edge the PC register loads,
                // so take it from the value being written rather than the old pc
                state_d    = FETCH;
                mem_req_d  = 1'b1;
                mem_we_d   = 1'b0;
                mem_addr_d = pc_next_q;
            end
`ifdef RSSB_HALT_EN
            HALT: begin
                state_d = HALT;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
`ifdef RSSB_HALT_EN
        halted_d = (state_d == HALT);
        busy_d   = busy_d && !halted_d;
`endif
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            pc_we_q     <= 1'b0;
            pc_next_q   <= '0;
            acc_we_q    <= 1'b0;
            acc_next_q  <= '0;
            diff_q      <= '0;
`ifdef RSSB_HALT_EN
            halted_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            pc_we_q     <= pc_we_d;
            pc_next_q   <= pc_next_d;
            acc_we_q    <= acc_we_d;
            acc_next_q  <= acc_next_d;
            diff_q      <= diff_d;
`ifdef RSSB_HALT_EN
            halted_q    <= halted_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign pc_we     = pc_we_q;
    assign pc_next   = pc_next_q;
    assign acc_we    = acc_we_q;
    assign acc_next  = acc_next_q;
`ifdef RSSB_HALT_EN
    assign halted    = halted_q;
`else
    assign halted    = 1'b0;
`endif

endmodule

// File: doc/rssb_ctrl.md
# rssb_ctrl

Sequencer for the RSSB (reverse-subtract-and-skip-if-borrow) core. It fetches each instruction word (an operand address) from shared memory and reads the operand. It computes `mem[x] - acc`, writes the result back to memory, and drives the write strobes and next values of the PC and ACC `reg_mem` instances directly downstream. The sequencer holds no architectural state; PC and ACC live in those registers and are fed back as inputs.

## Interface

Reset is synchronous and active-high on `rst`, sampled on the rising edge of `clk`. Single clock domain.

**Parameters**
- `WIDTH`, default 8: data and address width of PC, ACC and memory.
- `HALT_WORD`, default 8'hFF: instruction word that stops the core. Only honoured when `RSSB_HALT_EN` is defined.

**Ports**
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `start` in 1: single-cycle pulse that begins execution from the current `pc`.
- `busy` out 1: high while not in IDLE or HALT.
- `halted` out 1: high in HALT.
- `pc` in WIDTH: current PC from the PC register.
- `acc` in WIDTH: current ACC from the ACC register.
- `pc_we` out 1: PC register write strobe.
- `pc_next` out WIDTH: value written to PC.
- `acc_we` out 1: ACC register write strobe.
- `acc_next` out WIDTH: value written to ACC.
- `mem_req` out 1: memory request.
- `mem_we` out 1: request is a write when high, a read when low.
- `mem_addr` out WIDTH: request address.
- `mem_wdata` out WIDTH: write data.
- `mem_rdata` in WIDTH: read data, valid in the cycle `mem_ready` is high.
- `mem_ready` in 1: completes the current request.

## Operation

**States:** IDLE, FETCH, READ, WRITE, UPDATE, HALT.

**Transitions**
- IDLE → FETCH on `start`.
- FETCH, `mem_req`=1, `mem_we`=0, `mem_addr`=`pc`. On `mem_ready`:
  - latch x = `mem_rdata`;
  - go to READ.
- READ, read at x. On `mem_ready`:
  - latch diff = {1'b0, `mem_rdata`} - {1'b0, `acc`}, WIDTH+1 bits;
  - borrow = diff[WIDTH], i.e. `mem_rdata` < `acc` unsigned;
  - go to WRITE.
- WRITE, `mem_we`=1, `mem_addr`=x, `mem_wdata`=diff[WIDTH-1:0]. On `mem_ready` go to UPDATE.
- UPDATE, one cycle:
  - `acc_we`=1, `acc_next`=diff[WIDTH-1:0];
  - `pc_we`=1, `pc_next`=`pc` + 1 + borrow, modulo 2^WIDTH, so 8'hFF+1 → 8'h00 and 8'hFE+2 → 8'h00;
  - go to FETCH.
- HALT is left only by `rst`.

**Rules**
- `start` is ignored outside IDLE.
- All outputs are registered.
- `mem_addr`, `mem_we` and `mem_wdata` are held stable while `mem_req`=1 and `mem_ready`=0.
- `mem_req` stays high across back-to-back requests.
- `pc_we` and `acc_we` are asserted only in UPDATE, exactly once per instruction.
- `mem_ready` is ignored while `mem_req`=0.

**Reset**
- All outputs go to 0 and the state goes to IDLE.
- A reset mid-instruction aborts it. No `pc_we`/`acc_we` is issued for the aborted instruction. A write already accepted with `mem_ready` is not undone.

## Timing

- Zero-wait memory (`mem_ready` tied 1): 4 cycles per instruction (FETCH, READ, WRITE, UPDATE).
- `mem_req` rises on the first clock edge after `start` is sampled.
- Each wait cycle (`mem_ready`=0) adds one cycle to its phase.
- The updated `pc` and `acc` are visible on the inputs in the cycle after UPDATE, which is the first FETCH cycle. FETCH uses the new `pc`.

## Configuration

- `RSSB_HALT_EN` defined:
  - in FETCH, a fetched word equal to `HALT_WORD` moves the block to HALT;
  - no READ, WRITE or register update occurs for that word;
  - `halted`=1 and `busy`=0 from the next cycle.
- `RSSB_HALT_EN` undefined:
  - the HALT state and `halted` logic are removed, and `halted` is tied 0;
  - `HALT_WORD` is executed as a normal operand address.

## Test plan

- Basic subtract, zero-wait: `pc`=0, `acc`=3, mem[0]=8'h10, mem[8'h10]=8'h05, pulse `start`.
  - mem[8'h10]←8'h02;
  - UPDATE on cycle 4 with `acc_next`=8'h02, `pc_next`=8'h01.
- Borrow skip: `acc`=8'h07, mem[x]=8'h05.
  - mem[x]←8'hFE, `acc_next`=8'hFE;
  - `pc_next`=`pc`+2.
- PC wrap: `pc`=8'hFF with no borrow gives `pc_next`=8'h00. `pc`=8'hFE with borrow gives `pc_next`=8'h00.
- Wait states: `mem_ready` low for 3 cycles on each phase.
  - addr/we/wdata stay stable throughout;
  - the instruction takes 13 cycles;
  - `pc_we` and `acc_we` each pulse once.
- Reset mid-operation: assert `rst` during READ.
  - next cycle: all outputs 0, state IDLE;
  - no strobe issued;
  - `start` afterwards refetches from the unchanged `pc`.
- With `RSSB_HALT_EN`: mem[`pc`]=8'hFF.
  - `halted`=1 and `busy`=0;
  - no WRITE request and no strobes;
  - `start` is ignored.

  Without the macro, the same program reads and writes mem[8'hFF].
